// File: rtl/pi_ratio_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_ratio_divider_pkg
//  Description : Shared widths, FSM state encoding and result helpers for the
//                pi ratio divider (4*inside/total as unsigned Q2.FRAC_W).
//                Contents:
//                  CNT_W    width of the sampler hit counters
//                  FRAC_W   fraction bits of the result
//                  RES_W    result width (FRAC_W + 2 integer bits)
//                  DIV_N    quotient bits produced, one per DIV cycle
//                  ITER_W   width of the DIV iteration counter
//                  state_t  IDLE / DIV / DONE encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package pi_ratio_divider_pkg;

    localparam int CNT_W  = 10;
    localparam int FRAC_W = 6;
    localparam int RES_W  = FRAC_W + 2;
    localparam int DIV_N  = CNT_W + RES_W;
    localparam int ITER_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Any quotient bit above the Q2.FRAC_W window means the ratio is >= 4.0.
    function automatic logic quot_overflow(input logic [DIV_N-1:0] quot);
        return |quot[DIV_N-1:RES_W];
    endfunction

    function automatic logic [RES_W-1:0] quot_clamp(input logic [DIV_N-1:0] quot);
        return quot_overflow(quot) ? {RES_W{1'b1}} : quot[RES_W-1:0];
    endfunction

endpackage : pi_ratio_divider_pkg
`default_nettype wire

// File: rtl/pi_ratio_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : pi_ratio_divider_if
//  Description : Request/result bundle of the pi ratio divider.
//                master : start, cnt_total, cnt_inside   (requester drives)
//                slave  : busy, done, result, div_zero, sat (divider drives)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pi_ratio_divider_if;
    import pi_ratio_divider_pkg::*;

    logic             start;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_inside;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             div_zero;
    logic             sat;

    modport master (
        output start, cnt_total, cnt_inside,
        input  busy, done, result, div_zero, sat
    );

    modport slave (
        input  start, cnt_total, cnt_inside,
        output busy, done, result, div_zero, sat
    );

endinterface : pi_ratio_divider_if
`default_nettype wire

// File: rtl/pi_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : pi_div_step
//  Description : One combinational restoring-division step.
//                rem_in  [W:0]   partial remainder (always < divisor)
//                bit_in          next dividend bit, MSB first
//                divisor [W-1:0]
//                rem_out [W:0]   updated remainder
//                q_bit           quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_div_step
    import pi_ratio_divider_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  wire logic [W:0]   rem_in,
    input  wire logic         bit_in,
    input  wire logic [W-1:0] divisor,
    output logic      [W:0]   rem_out,
    output logic              q_bit
);

    // rem_in < divisor < 2^W, so the shifted trial value fits W+1 bits and
    // rem_in[W] is normally zero. It still forces a subtract if ever set, and
    // the modulo-2^(W+1) difference stays correct in that case.
    logic [W:0] w_trial;

    assign w_trial = {rem_in[W-1:0], bit_in};
    assign q_bit   = rem_in[W] | (w_trial >= {1'b0, divisor});
    assign rem_out = q_bit ? (w_trial - {1'b0, divisor}) : w_trial;

endmodule : pi_div_step
`default_nettype wire

// File: rtl/pi_ratio_divider.sv
`default_nettype none
// ============================================================================
//  Module      : pi_ratio_divider
//  Description : Iterative restoring divider producing the pi estimate
//                floor(4*inside*2^FRAC_W/total), saturated to all-ones,
//                one quotient bit per clock.
//                clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                bus.start/cnt_total/cnt_inside  request and operands
//                bus.busy   accepted request in flight (through done cycle)
//                bus.done   one-cycle pulse, result/flags updated this cycle
//                bus.result Q2.FRAC_W estimate, held between operations
//                bus.div_zero / bus.sat  status of the last operation
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_ratio_divider
    import pi_ratio_divider_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    pi_ratio_divider_if.slave bus
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIV_N - 1);

    state_t             r_state;
    logic [ITER_W-1:0]  r_iter;
    logic [CNT_W-1:0]   r_divisor;
    logic [CNT_W:0]     r_rem;
    // Dividend bits leave at the top while quotient bits enter at the bottom;
    // after DIV_N steps the register holds the complete quotient.
    logic [DIV_N-1:0]   r_work;
    logic               r_busy;
    logic               r_done;
    logic [RES_W-1:0]   r_result;
    logic               r_div_zero;
    logic               r_sat;

    logic [CNT_W:0]     w_rem_next;
    logic               w_q;
    logic [DIV_N-1:0]   w_quot;

    pi_div_step #(
        .W (CNT_W)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_work[DIV_N-1]),
        .divisor (r_divisor),
        .rem_out (w_rem_next),
        .q_bit   (w_q)
    );

    // Quotient including the bit being produced this cycle; on the last DIV
    // cycle this is final, so result and flags register on the DONE entry edge.
    assign w_quot = {r_work[DIV_N-2:0], w_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_iter     <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_work     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.cnt_total == '0) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_result   <= '0;
                            r_div_zero <= 1'b1;
                            r_sat      <= 1'b0;
                        end else begin
                            r_state   <= ST_DIV;
                            r_divisor <= bus.cnt_total;
                            r_work    <= {bus.cnt_inside, {RES_W{1'b0}}};
                            r_rem     <= '0;
                            r_iter    <= '0;
                        end
                    end
                end
                ST_DIV: begin
                    r_rem  <= w_rem_next;
                    r_work <= w_quot;
                    r_iter <= r_iter + ITER_W'(1);
                    if (r_iter == ITER_LAST) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_result   <= quot_clamp(w_quot);
                        r_sat      <= quot_overflow(w_quot);
                        r_div_zero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.div_zero = r_div_zero;
    assign bus.sat      = r_sat;

endmodule : pi_ratio_divider
`default_nettype wire

// File: tb/tb_pi_ratio_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_ratio_divider
//  Description : Scoreboard bench for pi_ratio_divider. Stimulus pushes the
//                arithmetic expectation (result, flags, done edge); a monitor
//                pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_ratio_divider;
    import pi_ratio_divider_pkg::*;

    typedef struct {
        int res;
        int sat;
        int dz;
        int at;     // posedge count at which done must be visible
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_cnt;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t mon_e;

    pi_ratio_divider_if bus ();

    pi_ratio_divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result",      int'(bus.result),   mon_e.res);
                chk("sat",         int'(bus.sat),      mon_e.sat);
                chk("div_zero",    int'(bus.div_zero), mon_e.dz);
                chk("done_timing", edge_cnt,           mon_e.at);
                chk("busy_at_done", int'(bus.busy),    1);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic issue(input int ins, input int tot, input bit hold);
        int   guard;
        int   q;
        exp_t e;
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: busy still %0b after %0d cycles", bus.busy, guard);
            return;
        end
        bus.cnt_inside = CNT_W'(ins);
        bus.cnt_total  = CNT_W'(tot);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        if (tot == 0) begin
            e.res = 0; e.sat = 0; e.dz = 1; e.at = edge_cnt;
        end else begin
            q     = (ins * (1 << RES_W)) / tot;
            e.sat = (q > (1 << RES_W) - 1) ? 1 : 0;
            e.res = (e.sat != 0) ? (1 << RES_W) - 1 : q;
            e.dz  = 0;
            e.at  = edge_cnt + DIV_N;
        end
        sb.push_back(e);
        chk("busy_after_accept", int'(bus.busy), 1);
        if (hold) begin
            guard = 0;
            while (bus.done !== 1'b1 && guard < 40) begin
                bus.cnt_inside = CNT_W'($urandom);
                bus.cnt_total  = CNT_W'($urandom);
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 40) begin
                checks++;
                failures++;
                $display("FAIL hold_done_wait: no done within %0d cycles", guard);
            end
            bus.start = 1'b0;
        end else begin
            bus.start      = 1'b0;
            bus.cnt_inside = CNT_W'($urandom);
            bus.cnt_total  = CNT_W'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, ins, tot;
        checks   = 0;
        failures = 0;
        edge_cnt = 0;
        bus.start      = 1'b0;
        bus.cnt_inside = '0;
        bus.cnt_total  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     int'(bus.busy),     0);
        chk("rst_done",     int'(bus.done),     0);
        chk("rst_result",   int'(bus.result),   0);
        chk("rst_div_zero", int'(bus.div_zero), 0);
        chk("rst_sat",      int'(bus.sat),      0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(785, 1000, 1'b0);     // 3.125 -> 200
        issue(0, 1023, 1'b0);
        issue(512, 512, 1'b0);      // exactly 4.0 saturates
        issue(5, 0, 1'b0);          // zero divisor, done next cycle
        @(posedge clk); #1;
        chk("zero_busy_one_cycle", int'(bus.busy), 0);
        chk("zero_result_held",    int'(bus.result), 0);
        issue(300, 700, 1'b1);      // start held with changing operands
        drain();

        // Async reset in the middle of a divide
        issue(1023, 1, 1'b0);
        drain();
        chk("pre_reset_result", int'(bus.result), 255);
        issue(785, 1000, 1'b0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy",   int'(bus.busy),   0);
        chk("midreset_done",   int'(bus.done),   0);
        chk("midreset_result", int'(bus.result), 0);
        chk("midreset_sat",    int'(bus.sat),    0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(785, 1000, 1'b0);
        drain();

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 7);
            tot  = (mode == 0) ? 0 : $urandom_range(1, 1023);
            ins  = (mode == 1) ? tot : $urandom_range(0, 1023);
            issue(ins, tot, mode == 2);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pi_ratio_divider
`default_nettype wire
